// File: rtl/mem_access_pkg.sv
// Shared encodings for the load/store/jump memory access unit.
package mem_access_pkg;

  typedef enum logic [1:0] {
    OP_NOP = 2'b00,
    OP_LD  = 2'b01,
    OP_ST  = 2'b10,
    OP_JM  = 2'b11
  } op_e;

  typedef enum logic [1:0] {
    S_IDLE   = 2'b00,
    S_ACCESS = 2'b01,
    S_RESP   = 2'b10
  } state_e;

  typedef struct packed {
    logic        wb;
    logic        jump;
    logic        err;
    logic [5:0]  rd;
    logic [31:0] data;
  } rsp_t;

endpackage

// File: rtl/mem_access_unit.sv
// Single-outstanding memory access unit: accepts LD/ST/JM from the pipeline,
// strobes the data memory for WAIT_CYCLES+1 cycles and holds a response until taken.
module mem_access_unit
  import mem_access_pkg::*;
#(
  parameter int DEPTH       = 64,
  parameter int WAIT_CYCLES = 0
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [1:0]  req_op,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  input  logic [5:0]  req_rd,
  output logic        mem_read,
  output logic        mem_wrt,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic        rsp_wb,
  output logic [5:0]  rsp_rd,
  output logic [31:0] rsp_data,
  output logic        rsp_jump,
  output logic        rsp_err,
  output logic        stall
);

  localparam int CW = (WAIT_CYCLES > 0) ? $clog2(WAIT_CYCLES + 1) : 1;

  state_e        state, state_next;
  op_e           op_q;
  logic [31:0]   addr_q, wdata_q;
  logic [5:0]    rd_q;
  logic [CW-1:0] cnt;
  rsp_t          rsp_q;

  op_e  req_op_e;
  logic accept, in_range, last_access;

  assign req_op_e    = op_e'(req_op);
  assign accept      = (state == S_IDLE) && req_valid;
  assign in_range    = req_addr < 32'(DEPTH);
  assign last_access = (state == S_ACCESS) && (cnt == '0);

  // NOTE: sequential state uses non-blocking (<=) so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) state <= S_IDLE;
    else     state <= state_next;
  end

  // NOTE: state_next gets a default before the case so no path can infer a latch.
  always_comb begin
    state_next = state;
    unique case (state)
      S_IDLE:   if (req_valid && req_op_e != OP_NOP)
                  state_next = in_range ? S_ACCESS : S_RESP;
      S_ACCESS: if (cnt == '0) state_next = S_RESP;
      S_RESP:   if (rsp_ready) state_next = S_IDLE;
      default:  state_next = S_IDLE;
    endcase
  end

  // Request capture, wait counter and response register.
  always_ff @(posedge clk) begin
    if (rst) begin
      op_q    <= OP_NOP;
      addr_q  <= '0;
      wdata_q <= '0;
      rd_q    <= '0;
      cnt     <= '0;
      rsp_q   <= '0;
    end else if (accept) begin
      op_q    <= req_op_e;
      addr_q  <= req_addr;
      wdata_q <= req_wdata;
      rd_q    <= req_rd;
      cnt     <= CW'(WAIT_CYCLES);
      // Out-of-range requests skip the memory entirely and report an error.
      if (!in_range && req_op_e != OP_NOP)
        rsp_q <= '{wb: 1'b0, jump: 1'b0, err: 1'b1, rd: req_rd, data: 32'd0};
    end else if (state == S_ACCESS) begin
      if (!last_access) begin
        cnt <= cnt - CW'(1);
      end else begin
        unique case (op_q)
          OP_LD:   rsp_q <= '{wb: 1'b1, jump: 1'b0, err: 1'b0, rd: rd_q, data: mem_rdata};
          OP_JM:   rsp_q <= '{wb: 1'b0, jump: 1'b1, err: 1'b0, rd: rd_q, data: mem_rdata};
          default: rsp_q <= '{wb: 1'b0, jump: 1'b0, err: 1'b0, rd: rd_q, data: 32'd0};
        endcase
      end
    end
  end

  always_comb begin
    req_ready = (state == S_IDLE);
    stall     = (state != S_IDLE);
    mem_read  = (state == S_ACCESS) && (op_q == OP_LD || op_q == OP_JM);
    mem_wrt   = (state == S_ACCESS) && (op_q == OP_ST);
    mem_addr  = addr_q;
    mem_wdata = wdata_q;
    rsp_valid = (state == S_RESP);
    rsp_wb    = rsp_q.wb;
    rsp_rd    = rsp_q.rd;
    rsp_data  = rsp_q.data;
    rsp_jump  = rsp_q.jump;
    rsp_err   = rsp_q.err;
  end

endmodule

// File: tb/tb_mem_access_unit.sv
// Scoreboard bench for mem_access_unit: one instance with WAIT_CYCLES=0, one with 2.
module tb_mem_access_unit;
  import mem_access_pkg::*;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        req_valid0 = 1'b0, req_valid2 = 1'b0;
  logic [1:0]  req_op = 2'b00;
  logic [31:0] req_addr = '0, req_wdata = '0;
  logic [5:0]  req_rd = '0;
  logic        rsp_ready = 1'b1;

  logic        req_ready0, mem_read0, mem_wrt0, rsp_valid0, rsp_wb0, rsp_jump0, rsp_err0, stall0;
  logic [31:0] mem_addr0, mem_wdata0, mem_rdata0, rsp_data0;
  logic [5:0]  rsp_rd0;
  logic        req_ready2, mem_read2, mem_wrt2, rsp_valid2, rsp_wb2, rsp_jump2, rsp_err2, stall2;
  logic [31:0] mem_addr2, mem_wdata2, mem_rdata2, rsp_data2;
  logic [5:0]  rsp_rd2;

  always #5 clk = ~clk;

  mem_access_unit #(.DEPTH(64), .WAIT_CYCLES(0)) dut0 (
    .clk(clk), .rst(rst), .req_valid(req_valid0), .req_ready(req_ready0),
    .req_op(req_op), .req_addr(req_addr), .req_wdata(req_wdata), .req_rd(req_rd),
    .mem_read(mem_read0), .mem_wrt(mem_wrt0), .mem_addr(mem_addr0),
    .mem_wdata(mem_wdata0), .mem_rdata(mem_rdata0),
    .rsp_valid(rsp_valid0), .rsp_ready(rsp_ready), .rsp_wb(rsp_wb0), .rsp_rd(rsp_rd0),
    .rsp_data(rsp_data0), .rsp_jump(rsp_jump0), .rsp_err(rsp_err0), .stall(stall0)
  );

  mem_access_unit #(.DEPTH(64), .WAIT_CYCLES(2)) dut2 (
    .clk(clk), .rst(rst), .req_valid(req_valid2), .req_ready(req_ready2),
    .req_op(req_op), .req_addr(req_addr), .req_wdata(req_wdata), .req_rd(req_rd),
    .mem_read(mem_read2), .mem_wrt(mem_wrt2), .mem_addr(mem_addr2),
    .mem_wdata(mem_wdata2), .mem_rdata(mem_rdata2),
    .rsp_valid(rsp_valid2), .rsp_ready(rsp_ready), .rsp_wb(rsp_wb2), .rsp_rd(rsp_rd2),
    .rsp_data(rsp_data2), .rsp_jump(rsp_jump2), .rsp_err(rsp_err2), .stall(stall2)
  );

  // Data memories: read data becomes valid at the negedge where mem_read is high.
  logic [31:0] mem0 [64] = '{0: 32'd1, 1: 32'hFFFF_FFFC, 2: 32'd6, 3: 32'd0, 4: 32'd5, default: 32'd0};
  logic [31:0] mem2 [64] = '{0: 32'd1, 1: 32'hFFFF_FFFC, 2: 32'd6, 3: 32'd0, 4: 32'd5, default: 32'd0};
  int rd_cnt0 = 0, wr_cnt0 = 0, rd_cnt2 = 0, wr_cnt2 = 0, both_cnt = 0;

  always @(negedge clk) begin
    if (mem_read0) mem_rdata0 <= (mem_addr0 < 64) ? mem0[mem_addr0[5:0]] : 32'hDEAD_BEEF;
    if (mem_wrt0 && mem_addr0 < 64) mem0[mem_addr0[5:0]] <= mem_wdata0;
    if (mem_read2) mem_rdata2 <= (mem_addr2 < 64) ? mem2[mem_addr2[5:0]] : 32'hDEAD_BEEF;
    if (mem_wrt2 && mem_addr2 < 64) mem2[mem_addr2[5:0]] <= mem_wdata2;
    rd_cnt0  += int'(mem_read0);
    wr_cnt0  += int'(mem_wrt0);
    rd_cnt2  += int'(mem_read2);
    wr_cnt2  += int'(mem_wrt2);
    both_cnt += int'(mem_read0 && mem_wrt0) + int'(mem_read2 && mem_wrt2);
  end

  // View of whichever instance is currently under test.
  logic        sel = 1'b0;
  logic        req_ready_c, rsp_valid_c, rsp_wb_c, rsp_jump_c, rsp_err_c, stall_c;
  logic [31:0] rsp_data_c;
  logic [5:0]  rsp_rd_c;
  assign req_ready_c = sel ? req_ready2 : req_ready0;
  assign rsp_valid_c = sel ? rsp_valid2 : rsp_valid0;
  assign rsp_wb_c    = sel ? rsp_wb2    : rsp_wb0;
  assign rsp_jump_c  = sel ? rsp_jump2  : rsp_jump0;
  assign rsp_err_c   = sel ? rsp_err2   : rsp_err0;
  assign stall_c     = sel ? stall2     : stall0;
  assign rsp_data_c  = sel ? rsp_data2  : rsp_data0;
  assign rsp_rd_c    = sel ? rsp_rd2    : rsp_rd0;

  int n_cmp = 0, n_bad = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  typedef struct {
    logic        wb;
    logic        jump;
    logic        err;
    logic [5:0]  rd;
    logic [31:0] data;
  } exp_t;

  exp_t        exp_q[$];
  logic [31:0] ref_mem [2][64];

  task automatic transact(input logic s, input op_e op, input logic [31:0] addr,
                          input logic [31:0] wdata, input logic [5:0] rd, input int hold);
    exp_t e;
    int   wait_n, lat, rd0, wr0, exp_rd, exp_wr;
    logic [31:0] held;
    sel    = s;
    wait_n = s ? 2 : 0;
    rd0    = s ? rd_cnt2 : rd_cnt0;
    wr0    = s ? wr_cnt2 : wr_cnt0;
    check("ready_before", 32'(req_ready_c), 32'd1);
    rsp_ready = (hold == 0);
    req_op = op; req_addr = addr; req_wdata = wdata; req_rd = rd;
    if (s) req_valid2 = 1'b1; else req_valid0 = 1'b1;
    @(posedge clk); #1;
    req_valid0 = 1'b0; req_valid2 = 1'b0;
    if (op == OP_NOP) begin
      check("nop_ready", 32'(req_ready_c), 32'd1);
      check("nop_no_rsp", 32'(rsp_valid_c), 32'd0);
      return;
    end
    // Expected response from the bench's own reference memory.
    e.err = (addr >= 64); e.rd = rd; e.wb = 1'b0; e.jump = 1'b0; e.data = 32'd0;
    exp_rd = 0; exp_wr = 0;
    if (!e.err) begin
      case (op)
        OP_LD: begin e.wb = 1'b1; e.data = ref_mem[s][addr[5:0]]; exp_rd = wait_n + 1; end
        OP_JM: begin e.jump = 1'b1; e.data = ref_mem[s][addr[5:0]]; exp_rd = wait_n + 1; end
        default: begin ref_mem[s][addr[5:0]] = wdata; exp_wr = wait_n + 1; end
      endcase
    end
    exp_q.push_back(e);
    lat = 0;
    while (!rsp_valid_c && lat < 20) begin
      @(posedge clk); #1;
      lat++;
    end
    check("latency", 32'(lat), e.err ? 32'd0 : 32'(wait_n + 1));
    e = exp_q.pop_front();
    check("rsp_data", rsp_data_c, e.data);
    check("rsp_rd", 32'(rsp_rd_c), 32'(e.rd));
    check("rsp_wb", 32'(rsp_wb_c), 32'(e.wb));
    check("rsp_jump", 32'(rsp_jump_c), 32'(e.jump));
    check("rsp_err", 32'(rsp_err_c), 32'(e.err));
    held = rsp_data_c;
    for (int i = 0; i < hold; i++) begin
      @(posedge clk); #1;
      check("hold_valid", 32'(rsp_valid_c), 32'd1);
      check("hold_data", rsp_data_c, held);
      check("hold_ready", 32'(req_ready_c), 32'd0);
      check("hold_stall", 32'(stall_c), 32'd1);
    end
    rsp_ready = 1'b1;
    @(posedge clk); #1;
    check("idle_ready", 32'(req_ready_c), 32'd1);
    check("idle_no_rsp", 32'(rsp_valid_c), 32'd0);
    check("read_cycles", 32'((s ? rd_cnt2 : rd_cnt0) - rd0), 32'(exp_rd));
    check("write_cycles", 32'((s ? wr_cnt2 : wr_cnt0) - wr0), 32'(exp_wr));
  endtask

  initial begin
    for (int k = 0; k < 64; k++) begin
      ref_mem[0][k] = 32'd0;
      ref_mem[1][k] = 32'd0;
    end
    ref_mem[0][0] = 32'd1; ref_mem[0][1] = 32'hFFFF_FFFC; ref_mem[0][2] = 32'd6; ref_mem[0][4] = 32'd5;
    ref_mem[1][0] = 32'd1; ref_mem[1][1] = 32'hFFFF_FFFC; ref_mem[1][2] = 32'd6; ref_mem[1][4] = 32'd5;

    repeat (2) @(posedge clk);
    #1;
    check("rst_req_ready", 32'(req_ready0), 32'd1);
    check("rst_stall", 32'(stall0), 32'd0);
    check("rst_mem_read", 32'(mem_read0), 32'd0);
    check("rst_mem_wrt", 32'(mem_wrt0), 32'd0);
    check("rst_mem_addr", mem_addr0, 32'd0);
    check("rst_mem_wdata", mem_wdata0, 32'd0);
    check("rst_rsp_valid", 32'(rsp_valid0), 32'd0);
    check("rst_rsp_flags", {29'd0, rsp_wb0, rsp_jump0, rsp_err0}, 32'd0);
    check("rst_rsp_rd", 32'(rsp_rd0), 32'd0);
    check("rst_rsp_data", rsp_data0, 32'd0);
    rst = 1'b0;
    @(posedge clk); #1;

    transact(1'b0, OP_LD, 32'd2,   32'd0,  6'd6,  0);
    transact(1'b0, OP_ST, 32'd3,   32'd10, 6'd0,  0);
    transact(1'b0, OP_LD, 32'd3,   32'd0,  6'd9,  0);
    transact(1'b0, OP_JM, 32'd4,   32'd0,  6'd2,  0);
    transact(1'b0, OP_LD, 32'd1,   32'd0,  6'd3,  3);
    transact(1'b0, OP_NOP, 32'd0,  32'd0,  6'd0,  0);
    transact(1'b0, OP_LD, 32'd64,  32'd0,  6'd5,  0);
    transact(1'b0, OP_ST, 32'd100, 32'd7,  6'd0,  1);
    transact(1'b1, OP_LD, 32'd0,   32'd0,  6'd1,  0);
    transact(1'b1, OP_JM, 32'd2,   32'd0,  6'd4,  0);

    // Reset in the middle of a multi-cycle access aborts it.
    sel = 1'b1;
    req_op = OP_LD; req_addr = 32'd4; req_rd = 6'd8; req_valid2 = 1'b1;
    @(posedge clk); #1;
    req_valid2 = 1'b0;
    @(posedge clk); #1;
    check("mid_access_read", 32'(mem_read2), 32'd1);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    check("abort_read", 32'(mem_read2), 32'd0);
    check("abort_wrt", 32'(mem_wrt2), 32'd0);
    check("abort_rsp_valid", 32'(rsp_valid2), 32'd0);
    check("abort_ready", 32'(req_ready2), 32'd1);
    check("abort_rsp_data", rsp_data2, 32'd0);
    repeat (4) begin
      @(posedge clk); #1;
      check("abort_no_rsp", 32'(rsp_valid2), 32'd0);
    end
    transact(1'b1, OP_LD, 32'd4, 32'd0, 6'd8, 0);

    check("queue_empty", 32'(exp_q.size()), 32'd0);
    check("strobe_overlap", 32'(both_cnt), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
